// File: rtl/field_array_regblock.sv
// field_array_regblock: N_REGS x {a,b,c} register block with hw load, hwset and increment paths
module field_array_regblock #(
  parameter int N_REGS = 3,
  parameter int FIELD_W = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter logic [FIELD_W-1:0] A_RST = '0,
  parameter logic [FIELD_W-1:0] B_RST = '0,
  parameter logic [FIELD_W-1:0] C_RST = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpuif_req,
  input  logic                      cpuif_req_is_wr,
  input  logic [ADDR_W-1:0]         cpuif_addr,
  input  logic [DATA_W-1:0]         cpuif_wr_data,
  input  logic [DATA_W-1:0]         cpuif_wr_biten,
  output logic                      cpuif_rd_ack,
  output logic                      cpuif_rd_err,
  output logic [DATA_W-1:0]         cpuif_rd_data,
  output logic                      cpuif_wr_ack,
  output logic                      cpuif_wr_err,
  input  logic [N_REGS-1:0]         hwif_a_we,
  input  logic [N_REGS*FIELD_W-1:0] hwif_a_next,
  input  logic [N_REGS*FIELD_W-1:0] hwif_b_hwset,
  input  logic [N_REGS-1:0]         hwif_c_incr,
  output logic [N_REGS*FIELD_W-1:0] hwif_a_value,
  output logic [N_REGS*FIELD_W-1:0] hwif_b_value,
  output logic [N_REGS*FIELD_W-1:0] hwif_c_value,
  output logic [N_REGS-1:0]         hwif_a_anded,
  output logic [N_REGS-1:0]         hwif_b_ored,
  output logic [N_REGS-1:0]         hwif_c_swmod,
  output logic [N_REGS-1:0]         hwif_c_overflow
);
  logic [ADDR_W-3:0] idx;
  logic err, rd, wr;
  logic [DATA_W-1:0] rd_mux;
  logic [FIELD_W-1:0] wd_a, wd_b, wd_c, be_a, be_b, be_c;
  assign idx = cpuif_addr[ADDR_W-1:2];
  assign err = 32'(idx) >= N_REGS;
  assign rd = cpuif_req & ~cpuif_req_is_wr;
  assign wr = cpuif_req & cpuif_req_is_wr;
  assign wd_a = cpuif_wr_data[FIELD_W-1:0];
  assign wd_b = cpuif_wr_data[2*FIELD_W-1:FIELD_W];
  assign wd_c = cpuif_wr_data[3*FIELD_W-1:2*FIELD_W];
  assign be_a = cpuif_wr_biten[FIELD_W-1:0];
  assign be_b = cpuif_wr_biten[2*FIELD_W-1:FIELD_W];
  assign be_c = cpuif_wr_biten[3*FIELD_W-1:2*FIELD_W];
  always_comb begin
    rd_mux = '0;
    for (int j = 0; j < N_REGS; j++)
      if (32'(idx) == j)
        rd_mux = DATA_W'({hwif_c_value[j*FIELD_W +: FIELD_W], hwif_b_value[j*FIELD_W +: FIELD_W],
                          hwif_a_value[j*FIELD_W +: FIELD_W]});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpuif_rd_ack  <= 1'b0;
      cpuif_rd_err  <= 1'b0;
      cpuif_rd_data <= '0;
      cpuif_wr_ack  <= 1'b0;
      cpuif_wr_err  <= 1'b0;
    end else begin
      cpuif_rd_ack  <= rd;
      cpuif_rd_err  <= rd & err;
      cpuif_rd_data <= (rd & ~err) ? rd_mux : '0;
      cpuif_wr_ack  <= wr;
      cpuif_wr_err  <= wr & err;
    end
  end
  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    logic [FIELD_W-1:0] a, b, c;
    logic hit, sw_a, sw_c, swmod, ovf;
    assign hit  = wr & ~err & (32'(idx) == i);
    assign sw_a = hit & |be_a;
    assign sw_c = hit & |be_c;
    // software writes win over hw load/increment; hwset is OR'd in after any write
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a     <= A_RST;
        b     <= B_RST;
        c     <= C_RST;
        swmod <= 1'b0;
        ovf   <= 1'b0;
      end else begin
        a     <= sw_a ? (a & ~be_a) | (wd_a & be_a) :
                 hwif_a_we[i] ? hwif_a_next[i*FIELD_W +: FIELD_W] : a;
        b     <= (hit ? (b & ~be_b) | (wd_b & be_b) : b) | hwif_b_hwset[i*FIELD_W +: FIELD_W];
        c     <= sw_c ? (c & ~be_c) | (wd_c & be_c) : c + FIELD_W'(hwif_c_incr[i]);
        swmod <= sw_c;
        ovf   <= ~sw_c & hwif_c_incr[i] & (&c);
      end
    end
    assign hwif_a_value[i*FIELD_W +: FIELD_W] = a;
    assign hwif_b_value[i*FIELD_W +: FIELD_W] = b;
    assign hwif_c_value[i*FIELD_W +: FIELD_W] = c;
    assign hwif_a_anded[i]    = &a;
    assign hwif_b_ored[i]     = |b;
    assign hwif_c_swmod[i]    = swmod;
    assign hwif_c_overflow[i] = ovf;
  end
endmodule

// File: doc/field_array_regblock.md
Name: field_array_regblock

Overview:
- Parametrised register block: N_REGS identical registers, each holding three FIELD_W-bit software-rw fields a, b and c.
- Sits between the CPU-interface bridge and datapath logic.
- Adds per-field hardware update paths to the structure of the earlier fixed 3x8-bit block:
  - a: hardware write-enable load.
  - b: per-bit hwset.
  - c: hardware increment counter with overflow pulse.
- Keeps the existing anded / ored / swmod outputs.

Parameters:
- N_REGS, 3, number of registers; valid range 1..64.
- FIELD_W, 8, width of each field a/b/c; 3*FIELD_W <= DATA_W.
- DATA_W, 32, CPU data width.
- ADDR_W, 8, CPU byte address width; must cover N_REGS*4.
- A_RST / B_RST / C_RST, 0, FIELD_W-bit reset values of fields a/b/c (same for all registers).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cpuif_req  in  1  request strobe; one transfer per asserted cycle.
- cpuif_req_is_wr  in  1  1 = write, 0 = read.
- cpuif_addr  in  ADDR_W  byte address.
- cpuif_wr_data  in  DATA_W  write data.
- cpuif_wr_biten  in  DATA_W  per-bit write enable.
- cpuif_rd_ack  out  1  read complete.
- cpuif_rd_err  out  1  read decode error.
- cpuif_rd_data  out  DATA_W  read data.
- cpuif_wr_ack  out  1  write complete.
- cpuif_wr_err  out  1  write decode error.
- hwif_a_we  in  N_REGS  per-register load enable for a.
- hwif_a_next  in  N_REGS*FIELD_W  load value for a.
- hwif_b_hwset  in  N_REGS*FIELD_W  per-bit set mask for b.
- hwif_c_incr  in  N_REGS  per-register increment pulse for c.
- hwif_a_value / hwif_b_value / hwif_c_value  out  N_REGS*FIELD_W  current field values; register i occupies slice [i*FIELD_W +: FIELD_W].
- hwif_a_anded  out  N_REGS  AND-reduction of a.
- hwif_b_ored  out  N_REGS  OR-reduction of b.
- hwif_c_swmod  out  N_REGS  c modified by software.
- hwif_c_overflow  out  N_REGS  c wrapped from all-ones to 0.

Behaviour:
- Reset (async assert, sync release to clk):
  - fields a/b/c = A_RST/B_RST/C_RST.
  - acks, errs, rd_data, swmod, overflow = 0.
  - anded/ored follow reset values.
- Register layout in the data word:
  - a = bits [FIELD_W-1:0].
  - b = bits [2*FIELD_W-1:FIELD_W].
  - c = bits [3*FIELD_W-1:2*FIELD_W].
  - unused bits read 0 and ignore writes.
- Decode:
  - index = cpuif_addr[ADDR_W-1:2]; cpuif_addr[1:0] ignored.
  - index >= N_REGS is a decode error.
- Latency is exactly 1 cycle. A request in cycle T asserts rd_ack or wr_ack for one cycle in T+1; no stall; back-to-back requests accepted every cycle.
- Read:
  - rd_data in T+1 = field values as stored at the T edge, i.e. pre-update for any same-cycle hw event.
  - Error: rd_err=1 and rd_data=0.
  - rd_data returns to 0 when rd_ack is low.
- Write:
  - Per bit, new = (old & ~biten) | (wdata & biten); takes effect at the T+1 edge.
  - Error: wr_err=1, no state change.
- Field a:
  - sw write has precedence over hwif_a_we in the same cycle; a byte-enabled sw write beats the hw load for the whole field.
  - Otherwise hwif_a_we loads hwif_a_next.
- Field b:
  - after any sw write, b |= hwif_b_hwset.
  - hwset wins per bit over a sw write of 0 in the same cycle.
- Field c:
  - hwif_c_incr adds 1 modulo 2^FIELD_W.
  - hwif_c_overflow[i] is a registered 1-cycle pulse, asserted in the cycle after an incr applied while c was all-ones.
  - A sw write with any biten bit in c's range in the same cycle wins: incr dropped, no overflow.
- swmod:
  - hwif_c_swmod[i] is a registered 1-cycle pulse, coincident with wr_ack, when a non-error write to register i had any biten set in c's range.
  - A write with all biten = 0 gives no swmod but is still acked.
- anded/ored are combinational reductions of the stored field values.
- Reset mid-transfer: pending ack dropped; no ack after reset release.

Test Plan (defaults: N_REGS=3, FIELD_W=8, DATA_W=32):
1. Reset, then read addr 0x0/0x4/0x8:
   - rd_ack in T+1, rd_data=0, rd_err=0.
   - anded=0, ored=0.
2. Write 0x00_33_22_FF to addr 0x4, biten=0xFFFFFFFF:
   - wr_ack and swmod[1]=1 for one cycle.
   - a[1]=0xFF, anded[1]=1; b[1]=0x22, ored[1]=1; c[1]=0x33.
   - Read back returns 0x00332 2FF (i.e. 0x003322FF).
3. Write biten=0x0000FF00 to addr 0x0:
   - only b[0] changes; swmod[0] stays 0.
   - Same cycle hwif_b_hwset[0]=0x01 with wdata b=0x00 -> b[0]=0x01.
4. Preload c[2]=0xFF, pulse hwif_c_incr[2]:
   - c[2]=0x00; overflow[2] pulses once.
   - Repeat with a simultaneous c write of 0x10 -> c[2]=0x10, no overflow.
5. hwif_a_we[0]=1, a_next=0x5A, same cycle as sw write a=0xA5:
   - a[0]=0xA5.
   - Next cycle with we only -> a[0]=0x5A.
6. Read and write addr 0xC (out of range):
   - rd_err=1 with rd_data=0; wr_err=1 with no field change.
   - Assert rst during a write request -> no ack, all fields reset.
